// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control FSM for the RISC-V datapath, with
// data-memory ready handshake and timeout, halt detection and a retire counter.
module control_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       Opcode,
  input  logic             z,
  input  logic             mem_ready,
  output logic             beq,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             busy,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t           state_q, state_d;
  logic [2:0]       ir_op_q, ir_op_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_r, is_ld, is_sd, is_beq, in_ex;
  assign is_r   = ~ir_op_q[2];
  assign is_ld  = ir_op_q == 3'b100;
  assign is_sd  = ir_op_q == 3'b101;
  assign is_beq = ir_op_q == 3'b110;
  assign in_ex  = state_q == EXEC || state_q == MEM || state_q == WB;
  always_comb begin
    state_d = state_q;
    ir_op_d = ir_op_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      IDLE:    state_d = start ? FETCH : IDLE;
      FETCH: begin
        state_d = DECODE;
        ir_op_d = Opcode;
      end
      DECODE:  state_d = &ir_op_q ? HALT : EXEC;
      EXEC: begin
        state_d = is_r ? WB : is_beq ? FETCH : MEM;
        wait_d  = 8'd0;
      end
      MEM:
        if (mem_ready) state_d = is_ld ? WB : FETCH;
        else if (wait_q == 8'(MEM_TIMEOUT - 1)) begin
          state_d = HALT;
          err_d   = 1'b1;
        end else wait_d = wait_q + 8'd1;
      WB:      state_d = FETCH;
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ir_op_q <= 3'b000;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_op_q <= ir_op_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (pc_write) cnt_q <= cnt_q + CNT_W'(1);
    end
  // sd retires in the MEM cycle that sees mem_ready, so its strobe follows mem_ready
  assign pc_write    = (state_q == EXEC && is_beq) || state_q == WB || (state_q == MEM && is_sd && mem_ready);
  assign beq         = state_q == EXEC && is_beq;
  assign mem_read    = state_q == MEM && is_ld;
  assign mem_write   = state_q == MEM && is_sd;
  assign reg_write   = state_q == WB;
  assign mem_to_reg  = state_q == WB && is_ld;
  assign alu_src     = in_ex && (is_ld || is_sd);
  assign alu_op      = !in_ex ? 2'b00 : is_r ? ir_op_q[1:0] : is_beq ? 2'b01 : 2'b00;
  assign busy        = state_q != IDLE && state_q != HALT;
  assign halted      = state_q == HALT;
  assign err         = err_q;
  assign instr_count = cnt_q;
  assign state       = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: scoreboard bench; each queued cycle carries its stimulus and the expected outputs.
module tb_control_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, z = 1'b0, mem_ready = 1'b0;
  logic [2:0] Opcode = 3'b000;
  logic beq, mem_read, mem_write, alu_src, mem_to_reg, reg_write, pc_write, busy, halted, err;
  logic [1:0] alu_op;
  logic [31:0] instr_count;
  logic [2:0] state;
  logic beq_b, mem_read_b, mem_write_b, alu_src_b, mem_to_reg_b, reg_write_b, pc_write_b, busy_b, halted_b, err_b;
  logic [1:0] alu_op_b, cnt_b;
  logic [2:0] state_b;
  int n_cmp = 0, n_fail = 0;
  logic [31:0] exp_cnt = 32'd0;

  typedef struct {
    logic s; logic [2:0] op; logic zz; logic mr;
    logic [14:0] v; logic [31:0] c;
  } cyc_t;
  cyc_t sb[$];

  always #5 clk = ~clk;

  control_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .Opcode(Opcode), .z(z), .mem_ready(mem_ready),
    .beq(beq), .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_op(alu_op), .pc_write(pc_write),
    .busy(busy), .halted(halted), .err(err), .instr_count(instr_count), .state(state));

  control_sequencer #(.CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .Opcode(Opcode), .z(z), .mem_ready(mem_ready),
    .beq(beq_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .alu_src(alu_src_b),
    .mem_to_reg(mem_to_reg_b), .reg_write(reg_write_b), .alu_op(alu_op_b), .pc_write(pc_write_b),
    .busy(busy_b), .halted(halted_b), .err(err_b), .instr_count(cnt_b), .state(state_b));

  function automatic logic [14:0] obs();
    return {state, pc_write, reg_write, beq, mem_read, mem_write, mem_to_reg, alu_src, alu_op, busy, halted, err};
  endfunction

  // f = {pc_write, reg_write, beq, mem_read, mem_write, mem_to_reg, alu_src}
  function automatic void push(input logic s, input logic [2:0] op, input logic zz, input logic mr,
                               input logic [2:0] st, input logic [6:0] f, input logic [1:0] aop, input logic er);
    cyc_t e;
    e.s = s; e.op = op; e.zz = zz; e.mr = mr; e.c = exp_cnt;
    e.v = {st, f, aop, (st != 3'd0) && (st != 3'd6), st == 3'd6, er};
    sb.push_back(e);
    if (f[6]) exp_cnt = exp_cnt + 32'd1;
  endfunction

  // Expected trace of one instruction from FETCH to its retiring cycle; Opcode is scrambled after FETCH.
  function automatic void push_instr(input logic [2:0] op, input int w, input logic s);
    logic [1:0] aop;
    logic mm, ld, sd, bq;
    aop = op == 3'd6 ? 2'b01 : op[2] ? 2'b00 : op[1:0];
    ld = op == 3'd4; sd = op == 3'd5; bq = op == 3'd6; mm = ld || sd;
    push(s, op, 1'b1, 1'b1, 3'd1, 7'b0, 2'b00, 1'b0);
    push(s, ~op, 1'b1, 1'b1, 3'd2, 7'b0, 2'b00, 1'b0);
    if (op == 3'd7) begin
      push(s, ~op, 1'b1, 1'b1, 3'd6, 7'b0, 2'b00, 1'b0);
      return;
    end
    push(s, ~op, 1'b1, 1'b1, 3'd3, {bq, 1'b0, bq, 3'b000, mm}, aop, 1'b0);
    if (mm) begin
      for (int i = 0; i < w; i++) push(s, ~op, 1'b1, 1'b0, 3'd4, {3'b000, ld, sd, 1'b0, 1'b1}, 2'b00, 1'b0);
      push(s, ~op, 1'b1, 1'b1, 3'd4, {sd, 2'b00, ld, sd, 2'b01}, 2'b00, 1'b0);
    end
    if (!bq && !sd) push(s, ~op, 1'b1, 1'b1, 3'd5, {2'b11, 3'b000, ld, ld}, aop, 1'b0);
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({obs(), instr_count, cnt_b} !== {15'd0, 32'd0, 2'd0}) begin
      n_fail++; $display("FAIL reset: got %h/%0d/%0d want 0/0/0", obs(), instr_count, cnt_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    cyc_t e;
    push(1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 7'b0, 2'b00, 1'b0);
    push(1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 7'b0, 2'b00, 1'b0);
    push_instr(3'd0, 0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL add: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    cyc_t e;
    for (int i = 1; i < 4; i++) push_instr(3'(i), 0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL rtype: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    cyc_t e;
    push_instr(3'd6, 0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL beq: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ld_wait();
    cyc_t e;
    push_instr(3'd4, 3, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL ld_wait: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sd_start_ignored();
    cyc_t e;
    push_instr(3'd5, 0, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL sd: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    cyc_t e;
    push_instr(3'd4, 0, 1'b0);
    push_instr(3'd5, 2, 1'b0);
    push_instr(3'd6, 0, 1'b1);
    push_instr(3'd3, 0, 1'b0);
    push_instr(3'd4, 1, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL b2b: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    cyc_t e;
    push(1'b0, 3'd5, 1'b0, 1'b0, 3'd1, 7'b0, 2'b00, 1'b0);
    push(1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 7'b0, 2'b00, 1'b0);
    push(1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 7'b0000001, 2'b00, 1'b0);
    for (int i = 0; i < 15; i++) push(1'b0, 3'd0, 1'b0, 1'b0, 3'd4, 7'b0000101, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 7'b0, 2'b00, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL timeout: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_op();
    cyc_t e;
    do_reset();
    push(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 7'b0, 2'b00, 1'b0);
    push_instr(3'd7, 0, 1'b0);
    push(1'b1, 3'd0, 1'b0, 1'b0, 3'd6, 7'b0, 2'b00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL halt: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b0;
    @(negedge clk); n_cmp++;
    if ({obs(), instr_count} !== {15'd0, 32'd0}) begin
      n_fail++; $display("FAIL halt_rst: got %h/%0d want 0/0", obs(), instr_count);
    end
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 32'd0;
  endtask

  task automatic test_rst_mid();
    cyc_t e;
    do_reset();
    push(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 7'b0, 2'b00, 1'b0);
    push_instr(3'd0, 0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL rst_mid: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      if (sb.size() > 0) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    #1 n_cmp++;
    if ({obs(), instr_count, cnt_b} !== {15'd0, 32'd0, 2'd0}) begin
      n_fail++; $display("FAIL rst_in_wb: got %h/%0d/%0d want 0/0/0", obs(), instr_count, cnt_b);
    end
    @(posedge clk); #1;
    rst = 1'b0; exp_cnt = 32'd0;
    @(negedge clk); n_cmp++;
    if ({obs(), instr_count} !== {15'd0, 32'd0}) begin
      n_fail++; $display("FAIL rst_after: got %h/%0d want 0/0", obs(), instr_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    cyc_t e;
    do_reset();
    push(1'b1, 3'd0, 1'b0, 1'b0, 3'd0, 7'b0, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) push_instr(3'd0, 0, 1'b0);
    push(1'b0, 3'd7, 1'b0, 1'b0, 3'd1, 7'b0, 2'b00, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); start = e.s; Opcode = e.op; z = e.zz; mem_ready = e.mr;
      @(negedge clk); n_cmp++;
      if ({obs(), instr_count, cnt_b} !== {e.v, e.c, e.c[1:0]}) begin
        n_fail++; $display("FAIL wrap: got %h/%0d/%0d want %h/%0d/%0d", obs(), instr_count, cnt_b, e.v, e.c, e.c[1:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype();
    test_beq();
    test_ld_wait();
    test_sd_start_ignored();
    test_back_to_back();
    test_timeout();
    test_halt_op();
    test_rst_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
